// File: rtl/keypad_digit_entry_if.sv
// Keypad entry bundle: raw key lines and controls in, accepted-digit stream
// and entry register out. master = keypad/controller side, slave = entry block.
interface keypad_digit_entry_if #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4
);
  logic [NUM_KEYS-1:0]            keyboard;
  logic                           enablen;
  logic                           clear;
  logic [3:0]                     bcd;
  logic                           valid_data;
  logic [4*DIGITS-1:0]            digits;
  logic [$clog2(DIGITS+1)-1:0]    digit_count;
  logic                           full;
  logic [1:0]                     fsm_state;

  // valid_data is a one-cycle strobe with no ready: the consumer must take
  // bcd/digits in the cycle valid_data is high; there is no back-pressure.
  modport master (
    output keyboard, enablen, clear,
    input  bcd, valid_data, digits, digit_count, full, fsm_state
  );

  modport slave (
    input  keyboard, enablen, clear,
    output bcd, valid_data, digits, digit_count, full, fsm_state
  );
endinterface

// File: rtl/keypad_digit_entry.sv
// Debounced one-hot keypad to BCD digit entry register (newest digit in [3:0]).
// Optional macro KEYPAD_MULTI_KEY_PRIORITY_EN: multi-key press resolves to highest index.
module keypad_digit_entry #(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_digit_entry_if.slave   kp
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DCNT_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_FULL  = DCNT_W'(DIGITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ACCEPT   = 2'd2,
    HELD     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_KEYS-1:0]    kb_q;
  logic [NUM_KEYS-1:0]    pat_q, pat_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;
  logic                   emit;
  logic [3:0]             code;
  logic                   valid_q;
  logic [3:0]             bcd_q;
  logic [4*DIGITS-1:0]    digits_q;
  logic [4*DIGITS-1:0]    digits_shift;
  logic [DCNT_W-1:0]      count_q;

  function automatic logic is_legal(input logic [NUM_KEYS-1:0] p);
`ifdef KEYPAD_MULTI_KEY_PRIORITY_EN
    return p != '0;
`else
    return (p != '0) && ((p & (p - NUM_KEYS'(1))) == '0);
`endif
  endfunction

  // Later (higher) indices overwrite earlier ones, so the highest set key wins.
  function automatic logic [3:0] encode(input logic [NUM_KEYS-1:0] p);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (p[i]) c = 4'(i);
    end
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (kb_q != '0) begin
          pat_d   = kb_q;
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (kb_q == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (kb_q == pat_q) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          pat_d = kb_q;
          cnt_d = CNT_W'(1);
        end
      end
      ACCEPT: begin
        cnt_d   = '0;
        state_d = HELD;
      end
      HELD: begin
        if (kb_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q + CNT_W'(1) == CNT_DONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // The edge that completes the stable run is the acceptance edge, so the
    // output registers update together and are visible during ACCEPT.
    if (state_d == DEBOUNCE && cnt_d == CNT_DONE) begin
      state_d = ACCEPT;
      accept  = 1'b1;
    end
    if (kp.enablen) begin
      state_d = IDLE;
      cnt_d   = '0;
      accept  = 1'b0;
    end
  end

  always_comb begin
    code         = encode(pat_d);
    emit         = accept && is_legal(pat_d);
    digits_shift = digits_q << 4;
    digits_shift[3:0] = code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kb_q    <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kb_q    <= kp.keyboard;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      bcd_q    <= 4'd0;
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q <= emit;
      if (emit) bcd_q <= code;
      // Clear wins over a same-edge shift; the strobe and bcd still report it.
      if (kp.clear) begin
        digits_q <= '0;
        count_q  <= '0;
      end else if (emit) begin
        digits_q <= digits_shift;
        if (count_q != DCNT_FULL) count_q <= count_q + DCNT_W'(1);
      end
    end
  end

  assign kp.valid_data  = valid_q;
  assign kp.bcd         = bcd_q;
  assign kp.digits      = digits_q;
  assign kp.digit_count = count_q;
  assign kp.full        = (count_q == DCNT_FULL);
  assign kp.fsm_state   = state_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: run-length keypad model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_keypad_digit_entry;

  localparam int NK = 10;
  localparam int DC = 4;
  localparam int ND = 4;

  logic clk;
  logic reset;

  keypad_digit_entry_if #(.NUM_KEYS(NK), .DIGITS(ND)) kp ();

  keypad_digit_entry #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .DIGITS(ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int cyc = 0;

  // Model: "armed" means a new press may be counted; run_len is the length
  // of the current run of one identical non-zero sample.
  logic [NK-1:0] m_kb;
  logic [3:0]    m_q[$];
  logic          m_valid;
  logic [3:0]    m_bcd;
  bit            armed = 1'b1;
  bit            skip = 1'b0;
  int            run_len = 0;
  int            zero_run = 0;
  logic [NK-1:0] run_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [NK-1:0] p);
`ifdef KEYPAD_MULTI_KEY_PRIORITY_EN
    return $countones(p) >= 1;
`else
    return $countones(p) == 1;
`endif
  endfunction

  function automatic logic [3:0] top_index(input logic [NK-1:0] p);
    for (int i = NK - 1; i >= 0; i--) begin
      if (p[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  task automatic model_step(input logic rst, input logic [NK-1:0] kb,
                            input logic en_n, input logic clr);
    logic [NK-1:0] s;
    bit acc;
    if (rst) begin
      m_kb = '0; m_q.delete(); m_valid = 1'b0; m_bcd = 4'd0;
      armed = 1'b1; skip = 1'b0; run_len = 0; zero_run = 0; run_pat = '0;
      return;
    end
    s = m_kb;
    m_kb = kb;
    acc = 1'b0;
    if (en_n) begin
      armed = 1'b1; run_len = 0; skip = 1'b0;
    end else if (armed) begin
      if (s == '0) run_len = 0;
      else if (run_len > 0 && s == run_pat) run_len++;
      else begin run_pat = s; run_len = 1; end
      if (run_len == DC) begin
        acc = 1'b1; armed = 1'b0; skip = 1'b1; zero_run = 0;
      end
    end else if (skip) begin
      skip = 1'b0;
    end else begin
      zero_run = (s == '0) ? zero_run + 1 : 0;
      if (zero_run == DC) begin armed = 1'b1; run_len = 0; end
    end
    m_valid = acc && legal(run_pat);
    if (m_valid) m_bcd = top_index(run_pat);
    if (clr) m_q.delete();
    else if (m_valid) begin
      m_q.push_front(m_bcd);
      if (m_q.size() > ND) void'(m_q.pop_back());
    end
  endtask

  // Per-cycle compare: inputs are stable at posedge, outputs sampled at negedge.
  initial begin
    logic [4*ND-1:0] exp_dig;
    logic [31:0] act_v, exp_v;
    forever begin
      @(posedge clk);
      model_step(reset, kp.keyboard, kp.enablen, kp.clear);
      @(negedge clk);
      cyc++;
      exp_dig = '0;
      for (int i = 0; i < m_q.size(); i++) exp_dig[4*i +: 4] = m_q[i];
      exp_v = {7'd0, m_valid, m_bcd, exp_dig, 3'(m_q.size()), (m_q.size() == ND)};
      act_v = {7'd0, kp.valid_data, kp.bcd, kp.digits, kp.digit_count, kp.full};
      check("model_outputs", act_v, exp_v);
      if (kp.valid_data) pulse_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int key, input int hold, input int rel);
    kp.keyboard = '0;
    kp.keyboard[key] = 1'b1;
    tick(hold);
    kp.keyboard = '0;
    tick(rel);
  endtask

  initial begin
    int p0;
    int pulse_tick;
    reset = 1'b1;
    kp.keyboard = '0;
    kp.enablen = 1'b0;
    kp.clear = 1'b0;
    tick(2);
    reset = 1'b0;
    check("reset_valid", 32'(kp.valid_data), 0);
    check("reset_digits", 32'(kp.digits), 0);
    check("reset_count", 32'(kp.digit_count), 0);
    check("reset_state", 32'(kp.fsm_state), 0);

    // 1: key 5 held 10 cycles, pulse expected on the 5th tick
    p0 = pulse_cnt;
    pulse_tick = -1;
    kp.keyboard = '0;
    kp.keyboard[5] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (kp.valid_data) pulse_tick = i + 1;
    end
    kp.keyboard = '0;
    tick(6);
    check("t1_pulses", 32'(pulse_cnt - p0), 1);
    check("t1_latency", 32'(pulse_tick), 5);
    check("t1_bcd", 32'(kp.bcd), 5);
    check("t1_digits", 32'(kp.digits), 32'h0005);
    check("t1_count", 32'(kp.digit_count), 1);

    // 2: bouncing key 2, then a too-short press of key 3
    p0 = pulse_cnt;
    kp.keyboard = 10'b0000000100; tick(1);
    kp.keyboard = '0;             tick(1);
    kp.keyboard = 10'b0000000100; tick(1);
    kp.keyboard = '0;             tick(1);
    press(2, 6, 6);
    check("t2_pulses", 32'(pulse_cnt - p0), 1);
    check("t2_bcd", 32'(kp.bcd), 2);
    p0 = pulse_cnt;
    press(3, 3, 6);
    check("t2_short_press", 32'(pulse_cnt - p0), 0);

    // 3: clear, then enter 1..5
    kp.clear = 1'b1; tick(1); kp.clear = 1'b0;
    for (int k = 1; k <= 4; k++) press(k, 6, 6);
    check("t3_full", 32'(kp.full), 1);
    check("t3_digits4", 32'(kp.digits), 32'h1234);
    press(5, 6, 6);
    check("t3_digits5", 32'(kp.digits), 32'h2345);
    check("t3_count", 32'(kp.digit_count), 4);

    // 4: keys 7+3 together, then key 1 before full release, then key 6
    p0 = pulse_cnt;
    kp.keyboard = 10'b0010001000; tick(6);
    kp.keyboard = 10'b0000000010; tick(6);
    kp.keyboard = '0; tick(6);
`ifdef KEYPAD_MULTI_KEY_PRIORITY_EN
    check("t4_multi_pulses", 32'(pulse_cnt - p0), 1);
    check("t4_multi_bcd", 32'(kp.bcd), 7);
    press(6, 6, 6);
    check("t4_digits", 32'(kp.digits), 32'h4576);
`else
    check("t4_multi_pulses", 32'(pulse_cnt - p0), 0);
    check("t4_multi_digits", 32'(kp.digits), 32'h2345);
    press(6, 6, 6);
    check("t4_digits", 32'(kp.digits), 32'h3456);
`endif
    check("t4_after_release", 32'(kp.bcd), 6);

    // 5: clear during the accept cycle of key 9
    kp.keyboard = '0;
    kp.keyboard[9] = 1'b1;
    tick(5);
    check("t5_valid", 32'(kp.valid_data), 1);
    check("t5_bcd", 32'(kp.bcd), 9);
    kp.clear = 1'b1; tick(1); kp.clear = 1'b0;
    check("t5_digits", 32'(kp.digits), 0);
    check("t5_count", 32'(kp.digit_count), 0);
    kp.keyboard = '0;
    tick(6);

    // 6: enablen during key 4, then reset mid-debounce
    p0 = pulse_cnt;
    kp.keyboard = '0;
    kp.keyboard[4] = 1'b1;
    tick(2);
    kp.enablen = 1'b1; tick(4);
    kp.enablen = 1'b0; tick(2);
    reset = 1'b1; kp.keyboard = '0; tick(1);
    reset = 1'b0; tick(2);
    check("t6_pulses", 32'(pulse_cnt - p0), 0);
    check("t6_bcd", 32'(kp.bcd), 0);
    check("t6_digits", 32'(kp.digits), 0);
    check("t6_full", 32'(kp.full), 0);
    check("t6_state", 32'(kp.fsm_state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
